// File: rtl/chirp_pkg.sv
// ---------------------------------------------------------------------------
// chirp_pkg
// Shared definitions for the chirp phase generator:
//   - default values for the chirp_phase_gen parameters
//   - MODE encodings for the frequency ramp (CW / up / down / triangle)
//   - FSM state type of the burst controller
// ---------------------------------------------------------------------------
package chirp_pkg;

    // Default parameter values
    localparam int DEF_PHASE_W    = 32;  // phase accumulator / FTW width
    localparam int DEF_ADDR_W     = 12;  // ROM address width (<= PHASE_W)
    localparam int DEF_CNT_W      = 27;  // sample / period counter width
    localparam int DEF_NP_W       = 5;   // pulse count width
    localparam int DEF_PHASE_CONT = 0;   // 0: phase restarts each pulse

    // Frequency ramp shape, as driven on MODE
    typedef enum logic [1:0] {
        MODE_CW   = 2'd0,   // constant frequency
        MODE_UP   = 2'd1,   // FTW rises by STEP each pulse sample
        MODE_DOWN = 2'd2,   // FTW falls by STEP each pulse sample
        MODE_TRI  = 2'd3    // rises for the first half of the pulse, then falls
    } mode_e;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for START
        LOAD   = 2'd1,  // validating the latched configuration
        RUN    = 2'd2,  // emitting samples
        FINISH = 2'd3   // one-cycle DONE state
    } state_e;

endpackage

// File: rtl/chirp_ftw_gen.sv
// ---------------------------------------------------------------------------
// chirp_ftw_gen
// Frequency tuning word ramp for one pulse. ftw holds FTW_k, the word used
// for pulse sample k. 'load' restarts the ramp at 'start' (k = 0); 'advance'
// moves from FTW_k to FTW_k+1 according to 'mode'. 'load' wins over
// 'advance' when both are asserted. All arithmetic wraps modulo 2^PHASE_W.
//
// Ports
//   CLK       in   clock
//   RESET     in   synchronous active-high reset (clears FTW and index)
//   load      in   restart ramp at 'start'
//   advance   in   step to the next FTW
//   mode      in   ramp shape (chirp_pkg::mode_e encoding)
//   start     in   FTW of pulse sample 0
//   step      in   unsigned per-sample FTW change
//   half_len  in   pulse length >> 1 (triangle turning point)
//   ftw       out  current FTW
// ---------------------------------------------------------------------------
module chirp_ftw_gen
    import chirp_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic               advance,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] start,
    input  logic [PHASE_W-1:0] step,
    input  logic [CNT_W-1:0]   half_len,
    output logic [PHASE_W-1:0] ftw
);

    logic [PHASE_W-1:0] r_ftw;
    logic [CNT_W-1:0]   r_k;        // index of the sample using r_ftw

    logic [CNT_W:0]     w_k_next;   // k+1, one bit wider so it cannot wrap
    logic               w_rising;
    logic [PHASE_W-1:0] w_ftw_next;

    assign w_k_next = {1'b0, r_k} + {{CNT_W{1'b0}}, 1'b1};

    // Triangle keeps climbing while the sample being prepared (k+1) is
    // still in the first half of the pulse.
    assign w_rising = (w_k_next < {1'b0, half_len});

    always_comb begin
        w_ftw_next = r_ftw;
        case (mode)
            MODE_CW:   w_ftw_next = r_ftw;
            MODE_UP:   w_ftw_next = r_ftw + step;
            MODE_DOWN: w_ftw_next = r_ftw - step;
            MODE_TRI:  w_ftw_next = w_rising ? (r_ftw + step) : (r_ftw - step);
            default:   w_ftw_next = r_ftw;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ftw <= '0;
            r_k   <= '0;
        end else if (load) begin
            r_ftw <= start;
            r_k   <= '0;
        end else if (advance) begin
            r_ftw <= w_ftw_next;
            r_k   <= w_k_next[CNT_W-1:0];
        end
    end

    assign ftw = r_ftw;

endmodule

// File: rtl/chirp_phase_gen.sv
// ---------------------------------------------------------------------------
// chirp_phase_gen
// Burst controller and phase accumulator for a chirp (linear FM) pulse train.
// A burst is NUM_PULSES periods of PERIOD_LEN samples; the first PULSE_LEN
// samples of each period are pulse samples carrying a ROM address taken from
// the top ADDR_W bits of the phase accumulator, the rest are gap samples with
// address 0. The last pulse has no trailing gap.
//
// Output handshake: ADDR and its flags form one output register. ADDR_VALID
// says the register holds a sample. On every RUN cycle with OUT_READY=1 the
// sample in the register (if any) is consumed and the next sample is loaded;
// with OUT_READY=0 the register, the counters and the FSM all hold. Once the
// LAST sample is consumed the register empties and the FSM moves to FINISH,
// so ADDR_VALID is 0 outside RUN.
//
// Ports
//   CLK           in   clock
//   RESET         in   synchronous active-high reset, highest priority
//   START         in   one-cycle burst request, only honoured in IDLE
//   MODE          in   0=CW, 1=up, 2=down, 3=triangle
//   FTW_START     in   FTW of the first sample of each pulse
//   FTW_STEP      in   unsigned per-sample FTW change
//   PULSE_LEN     in   samples per pulse
//   PERIOD_LEN    in   samples per period
//   NUM_PULSES    in   pulses per burst
//   OUT_READY     in   downstream accepts the sample on ADDR
//   ADDR          out  ROM address (0 for gap samples)
//   ADDR_VALID    out  ADDR holds a sample
//   PULSE_ACTIVE  out  sample is a pulse sample, not a gap sample
//   FIRST         out  first sample of the burst
//   LAST          out  last sample of the burst
//   BUSY          out  burst in progress (LOAD, RUN, FINISH)
//   DONE          out  one-cycle burst completion pulse
//   CFG_ERR       out  one-cycle rejected-configuration pulse
// ---------------------------------------------------------------------------
module chirp_phase_gen
    import chirp_pkg::*;
#(
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NP_W       = DEF_NP_W,
    parameter int PHASE_CONT = DEF_PHASE_CONT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [1:0]         MODE,
    input  logic [PHASE_W-1:0] FTW_START,
    input  logic [PHASE_W-1:0] FTW_STEP,
    input  logic [CNT_W-1:0]   PULSE_LEN,
    input  logic [CNT_W-1:0]   PERIOD_LEN,
    input  logic [NP_W-1:0]    NUM_PULSES,
    input  logic               OUT_READY,
    output logic [ADDR_W-1:0]  ADDR,
    output logic               ADDR_VALID,
    output logic               PULSE_ACTIVE,
    output logic               FIRST,
    output logic               LAST,
    output logic               BUSY,
    output logic               DONE,
    output logic               CFG_ERR
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NP_W-1:0]  NP_ONE  = {{(NP_W-1){1'b0}}, 1'b1};

    // FSM
    state_e r_state;
    state_e w_next_state;

    // Configuration latched on START
    logic [1:0]         r_mode;
    logic [PHASE_W-1:0] r_ftw_start;
    logic [PHASE_W-1:0] r_ftw_step;
    logic [CNT_W-1:0]   r_pulse_len;
    logic [CNT_W-1:0]   r_period_len;
    logic [NP_W-1:0]    r_num_pulses;

    // Position of the next sample to generate, and the accumulator
    logic [CNT_W-1:0]   r_s;        // sample index within the period
    logic [NP_W-1:0]    r_p;        // pulse (period) index within the burst
    logic [PHASE_W-1:0] r_phase;

    // Output register
    logic [ADDR_W-1:0]  r_addr;
    logic               r_valid;
    logic               r_active;
    logic               r_first;
    logic               r_last;
    logic               r_cfg_err;

    // Derived controls
    logic               w_cfg_bad;
    logic               w_in_pulse;
    logic               w_pulse_end;
    logic               w_period_end;
    logic               w_last_pulse;
    logic               w_gen_last;
    logic               w_out_done;
    logic               w_gen;
    logic               w_ftw_load;
    logic               w_ftw_adv;
    logic [CNT_W-1:0]   w_half_len;
    logic [PHASE_W-1:0] w_ftw;

    assign w_cfg_bad    = (r_pulse_len == '0) || (r_num_pulses == '0) ||
                          (r_period_len < r_pulse_len);
    assign w_in_pulse   = (r_s < r_pulse_len);
    assign w_pulse_end  = (r_s == (r_pulse_len - CNT_ONE));
    assign w_period_end = (r_s == (r_period_len - CNT_ONE));
    assign w_last_pulse = (r_p == (r_num_pulses - NP_ONE));
    assign w_gen_last   = w_last_pulse && w_pulse_end;

    // The final sample sits in the output register and is being consumed.
    assign w_out_done = (r_state == RUN) && OUT_READY && r_valid && r_last;

    // Generate a new sample into the output register. Once LAST has been
    // generated nothing further is produced; the burst just drains.
    assign w_gen = (r_state == RUN) && OUT_READY && !(r_valid && r_last);

    // The ramp restarts at FTW_START when the burst is set up and after the
    // final sample of every pulse, so each pulse starts from the same word.
    assign w_half_len = r_pulse_len >> 1;
    assign w_ftw_load = (r_state == LOAD) || (w_gen && w_in_pulse && w_pulse_end);
    assign w_ftw_adv  = w_gen && w_in_pulse;

    chirp_ftw_gen #(
        .PHASE_W (PHASE_W),
        .CNT_W   (CNT_W)
    ) u_ftw_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (w_ftw_load),
        .advance  (w_ftw_adv),
        .mode     (r_mode),
        .start    (r_ftw_start),
        .step     (r_ftw_step),
        .half_len (w_half_len),
        .ftw      (w_ftw)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (START) w_next_state = LOAD;
            LOAD:    w_next_state = w_cfg_bad ? IDLE : RUN;
            RUN:     if (w_out_done) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Configuration, counters, accumulator and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mode       <= '0;
            r_ftw_start  <= '0;
            r_ftw_step   <= '0;
            r_pulse_len  <= '0;
            r_period_len <= '0;
            r_num_pulses <= '0;
            r_s          <= '0;
            r_p          <= '0;
            r_phase      <= '0;
            r_addr       <= '0;
            r_valid      <= 1'b0;
            r_active     <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_mode       <= MODE;
                        r_ftw_start  <= FTW_START;
                        r_ftw_step   <= FTW_STEP;
                        r_pulse_len  <= PULSE_LEN;
                        r_period_len <= PERIOD_LEN;
                        r_num_pulses <= NUM_PULSES;
                    end
                end
                LOAD: begin
                    if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_s     <= '0;
                        r_p     <= '0;
                        r_phase <= '0;
                    end
                end
                RUN: begin
                    if (w_out_done) begin
                        // Final sample consumed: empty the output register.
                        r_addr   <= '0;
                        r_valid  <= 1'b0;
                        r_active <= 1'b0;
                        r_first  <= 1'b0;
                        r_last   <= 1'b0;
                    end else if (w_gen) begin
                        r_valid  <= 1'b1;
                        r_active <= w_in_pulse;
                        r_first  <= (r_s == '0) && (r_p == '0);
                        r_last   <= w_gen_last;
                        if (w_in_pulse) begin
                            // Address reflects the phase before this sample's increment.
                            r_addr <= r_phase[PHASE_W-1 -: ADDR_W];
                            if (w_pulse_end && (PHASE_CONT == 0)) begin
                                r_phase <= '0;
                            end else begin
                                r_phase <= r_phase + w_ftw;
                            end
                        end else begin
                            r_addr <= '0;
                        end
                        if (w_period_end) begin
                            r_s <= '0;
                            r_p <= r_p + NP_ONE;
                        end else begin
                            r_s <= r_s + CNT_ONE;
                        end
                    end
                end
                FINISH: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign ADDR         = r_addr;
    assign ADDR_VALID   = r_valid;
    assign PULSE_ACTIVE = r_active;
    assign FIRST        = r_first;
    assign LAST         = r_last;
    assign CFG_ERR      = r_cfg_err;
    assign BUSY         = (r_state != IDLE);
    assign DONE         = (r_state == FINISH);

endmodule
